// File: rtl/clock_core_if.sv
// Key inputs and digit-decoder outputs of the alarm-clock time core.
// The master modport is the key/decoder side; the slave modport is the core.
interface clock_core_if;
  logic       key_mode, key_inc;
  logic [3:0] h_tens, h_ones, m_tens, m_ones, s_tens, s_ones;
  logic       on_h, on_m, on_s, flash, sec_pulse;

  modport master (
    output key_mode, key_inc,
    input  h_tens, h_ones, m_tens, m_ones, s_tens, s_ones,
    input  on_h, on_m, on_s, flash, sec_pulse
  );
  modport slave (
    input  key_mode, key_inc,
    output h_tens, h_ones, m_tens, m_ones, s_tens, s_ones,
    output on_h, on_m, on_s, flash, sec_pulse
  );
endinterface

// File: rtl/clock_core.sv
// 24-hour BCD time-of-day counter with RUN / SET_H / SET_M edit modes.
// All outputs come straight from registers or from decoding the prescaler.
module clock_core #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic         clk,
  input  logic         rst,
  clock_core_if.slave  bus
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {RUN, SET_H, SET_M} state_e;

  state_e        state_q;
  logic [PW-1:0] pre_q;
  logic [3:0]    ht_q, ho_q, mt_q, mo_q, st_q, so_q;
  logic          on_h_q, on_m_q, sec_pulse_q;

  logic       wrap;
  logic       s_carry, m_carry;
  logic [3:0] st_d, so_d, mt_d, mo_d, ht_d, ho_d;

  assign wrap = (pre_q == PW'(TICK_DIV - 1));

  // Incremented value of each field; >= guards keep any digit from exceeding 9.
  always_comb begin
    s_carry = (st_q >= 4'd5) && (so_q >= 4'd9);
    m_carry = (mt_q >= 4'd5) && (mo_q >= 4'd9);
    so_d = (so_q >= 4'd9) ? 4'd0 : so_q + 4'd1;
    st_d = (so_q >= 4'd9) ? ((st_q >= 4'd5) ? 4'd0 : st_q + 4'd1) : st_q;
    mo_d = (mo_q >= 4'd9) ? 4'd0 : mo_q + 4'd1;
    mt_d = (mo_q >= 4'd9) ? ((mt_q >= 4'd5) ? 4'd0 : mt_q + 4'd1) : mt_q;
    ht_d = ht_q;
    ho_d = ho_q + 4'd1;
    if ((ht_q >= 4'd2) && (ho_q >= 4'd3)) begin
      ht_d = 4'd0;
      ho_d = 4'd0;
    end else if (ho_q >= 4'd9) begin
      ht_d = ht_q + 4'd1;
      ho_d = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      pre_q       <= '0;
      ht_q        <= '0;
      ho_q        <= '0;
      mt_q        <= '0;
      mo_q        <= '0;
      st_q        <= '0;
      so_q        <= '0;
      on_h_q      <= 1'b0;
      on_m_q      <= 1'b0;
      sec_pulse_q <= 1'b0;
    end else begin
      pre_q       <= wrap ? '0 : pre_q + 1'b1;
      sec_pulse_q <= wrap && (state_q == RUN);
      if (wrap && (state_q == RUN)) begin
        st_q <= st_d;
        so_q <= so_d;
        if (s_carry) begin
          mt_q <= mt_d;
          mo_q <= mo_d;
          if (m_carry) begin
            ht_q <= ht_d;
            ho_q <= ho_d;
          end
        end
      end
      if (bus.key_mode) begin
        case (state_q)
          RUN: begin
            state_q <= SET_H;
            on_h_q  <= 1'b1;
            on_m_q  <= 1'b0;
          end
          SET_H: begin
            state_q <= SET_M;
            on_h_q  <= 1'b0;
            on_m_q  <= 1'b1;
          end
          default: begin
            // Leaving edit restarts the second cleanly from :00.
            state_q <= RUN;
            on_h_q  <= 1'b0;
            on_m_q  <= 1'b0;
            st_q    <= '0;
            so_q    <= '0;
            pre_q   <= '0;
          end
        endcase
      end else if (bus.key_inc) begin
        if (state_q == SET_H) begin
          ht_q <= ht_d;
          ho_q <= ho_d;
        end else if (state_q == SET_M) begin
          mt_q <= mt_d;
          mo_q <= mo_d;
        end
      end
    end
  end

  assign bus.h_tens    = ht_q;
  assign bus.h_ones    = ho_q;
  assign bus.m_tens    = mt_q;
  assign bus.m_ones    = mo_q;
  assign bus.s_tens    = st_q;
  assign bus.s_ones    = so_q;
  assign bus.on_h      = on_h_q;
  assign bus.on_m      = on_m_q;
  assign bus.on_s      = 1'b0;
  assign bus.flash     = (pre_q >= PW'(TICK_DIV / 2));
  assign bus.sec_pulse = sec_pulse_q;
endmodule

// File: tb/tb_clock_core.sv
// Directed bench for clock_core at TICK_DIV = 4.
module tb_clock_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clock_core_if bus();
  clock_core #(.TICK_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int nvec = 0;
  int nerr = 0;
  int pre_m = 0;  // expected prescaler phase
  int st_m  = 0;  // expected mode: 0 RUN, 1 SET_H, 2 SET_M

  task automatic step();
    @(posedge clk); #1;
    pre_m = (pre_m + 1) % 4;
  endtask

  task automatic press(input logic m, input logic i);
    bus.key_mode = m;
    bus.key_inc  = i;
    @(posedge clk); #1;
    bus.key_mode = 1'b0;
    bus.key_inc  = 1'b0;
    if (m && st_m == 2) pre_m = 0;
    else pre_m = (pre_m + 1) % 4;
    if (m) st_m = (st_m + 1) % 3;
  endtask

  task automatic test_reset();
    bit ef [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit ep [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; bus.key_mode = 1'b0; bus.key_inc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones, bus.s_tens, bus.s_ones} !== 24'h0) begin
      nerr++; $display("FAIL reset_digits got %h want 000000",
        {bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones, bus.s_tens, bus.s_ones});
    end
    nvec++;
    if ({bus.on_h, bus.on_m, bus.on_s, bus.flash, bus.sec_pulse} !== 5'b0) begin
      nerr++; $display("FAIL reset_flags got %b want 00000",
        {bus.on_h, bus.on_m, bus.on_s, bus.flash, bus.sec_pulse});
    end
    rst = 1'b0; pre_m = 0; st_m = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      nvec++;
      if (bus.flash !== ef[k]) begin
        nerr++; $display("FAIL first_sec_flash[%0d] got %b want %b", k, bus.flash, ef[k]);
      end
      nvec++;
      if (bus.sec_pulse !== ep[k]) begin
        nerr++; $display("FAIL first_sec_pulse[%0d] got %b want %b", k, bus.sec_pulse, ep[k]);
      end
      nvec++;
      if (bus.s_ones !== ((k == 3) ? 4'd1 : 4'd0)) begin
        nerr++; $display("FAIL first_sec_digit[%0d] got %0d", k, bus.s_ones);
      end
    end
    step();
    nvec++;
    if (bus.sec_pulse !== 1'b0) begin
      nerr++; $display("FAIL pulse_width got %b want 0", bus.sec_pulse);
    end
  endtask

  task automatic test_set_hours();
    int h;
    bit seen_p, seen_f;
    press(1'b1, 1'b0);
    nvec++;
    if ({bus.on_h, bus.on_m, bus.on_s} !== 3'b100) begin
      nerr++; $display("FAIL seth_on got %b want 100", {bus.on_h, bus.on_m, bus.on_s});
    end
    for (int i = 0; i < 25; i++) begin
      press(1'b0, 1'b1);
      h = (i + 1) % 24;
      nvec++;
      if ({bus.h_tens, bus.h_ones} !== {4'(h / 10), 4'(h % 10)}) begin
        nerr++; $display("FAIL hour_inc[%0d] got %h want %0d", i, {bus.h_tens, bus.h_ones}, h);
      end
    end
    nvec++;
    if ({bus.m_tens, bus.m_ones, bus.s_tens, bus.s_ones} !== 16'h0001) begin
      nerr++; $display("FAIL seth_mmss got %h want 0001",
        {bus.m_tens, bus.m_ones, bus.s_tens, bus.s_ones});
    end
    seen_p = 1'b0; seen_f = 1'b0;
    repeat (12) begin
      step();
      seen_p |= bus.sec_pulse;
      seen_f |= bus.flash;
    end
    nvec++;
    if ({bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones, bus.s_tens, bus.s_ones} !== 24'h010001) begin
      nerr++; $display("FAIL seth_frozen got %h want 010001",
        {bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones, bus.s_tens, bus.s_ones});
    end
    nvec++;
    if ({seen_p, seen_f} !== 2'b01) begin
      nerr++; $display("FAIL seth_pulse_flash got %b want 01", {seen_p, seen_f});
    end
  endtask

  task automatic test_set_minutes();
    int m;
    press(1'b1, 1'b0);
    nvec++;
    if ({bus.on_h, bus.on_m} !== 2'b01) begin
      nerr++; $display("FAIL setm_on got %b want 01", {bus.on_h, bus.on_m});
    end
    for (int i = 0; i < 61; i++) begin
      press(1'b0, 1'b1);
      m = (i + 1) % 60;
      nvec++;
      if ({bus.m_tens, bus.m_ones} !== {4'(m / 10), 4'(m % 10)}) begin
        nerr++; $display("FAIL min_inc[%0d] got %h want %0d", i, {bus.m_tens, bus.m_ones}, m);
      end
    end
    nvec++;
    if ({bus.h_tens, bus.h_ones} !== 8'h01) begin
      nerr++; $display("FAIL setm_hours got %h want 01", {bus.h_tens, bus.h_ones});
    end
    press(1'b1, 1'b0);
    nvec++;
    if ({bus.on_h, bus.on_m, bus.flash, bus.s_tens, bus.s_ones} !== 11'b0) begin
      nerr++; $display("FAIL to_run got on=%b%b flash=%b sec=%h want 00 0 00",
        bus.on_h, bus.on_m, bus.flash, {bus.s_tens, bus.s_ones});
    end
    for (int k = 0; k < 4; k++) begin
      step();
      nvec++;
      if ({bus.sec_pulse, bus.s_ones} !== ((k == 3) ? 5'h11 : 5'h00)) begin
        nerr++; $display("FAIL first_tick[%0d] got pulse=%b s=%0d", k, bus.sec_pulse, bus.s_ones);
      end
    end
  endtask

  task automatic test_simultaneous();
    press(1'b1, 1'b1);
    nvec++;
    if ({bus.on_h, bus.h_tens, bus.h_ones} !== 9'h101) begin
      nerr++; $display("FAIL simul got on_h=%b h=%h want 1 01", bus.on_h, {bus.h_tens, bus.h_ones});
    end
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    nvec++;
    if ({bus.on_h, bus.on_m} !== 2'b00) begin
      nerr++; $display("FAIL simul_back got %b want 00", {bus.on_h, bus.on_m});
    end
  endtask

  task automatic test_rollover();
    int n;
    press(1'b1, 1'b0);
    repeat (22) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (58) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    nvec++;
    if ({bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones, bus.s_tens, bus.s_ones} !== 24'h235900) begin
      nerr++; $display("FAIL preload got %h want 235900",
        {bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones, bus.s_tens, bus.s_ones});
    end
    for (n = 1; n <= 60; n++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        if (pre_m == 0) break;
      end
      nvec++;
      if (bus.sec_pulse !== 1'b1) begin
        nerr++; $display("FAIL tick_pulse[%0d] got %b want 1", n, bus.sec_pulse);
      end
      nvec++;
      if (n < 60 && {bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones, bus.s_tens, bus.s_ones}
                    !== {16'h2359, 4'(n / 10), 4'(n % 10)}) begin
        nerr++; $display("FAIL tick_time[%0d] got %h", n,
          {bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones, bus.s_tens, bus.s_ones});
      end else if (n == 60 && {bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones, bus.s_tens, bus.s_ones}
                    !== 24'h000000) begin
        nerr++; $display("FAIL midnight got %h want 000000",
          {bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones, bus.s_tens, bus.s_ones});
      end
    end
    press(1'b0, 1'b1);
    nvec++;
    if ({bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones} !== 16'h0000) begin
      nerr++; $display("FAIL run_inc_ignored got %h want 0000",
        {bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones});
    end
  endtask

  task automatic test_reset_mid_edit();
    press(1'b1, 1'b0);
    repeat (12) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (34) press(1'b0, 1'b1);
    nvec++;
    if ({bus.on_m, bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones} !== 17'h11234) begin
      nerr++; $display("FAIL edit_1234 got on_m=%b %h", bus.on_m,
        {bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones});
    end
    #2 rst = 1'b1;
    #1;
    nvec++;
    if ({bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones, bus.s_tens, bus.s_ones} !== 24'h0) begin
      nerr++; $display("FAIL async_rst_digits got %h want 000000",
        {bus.h_tens, bus.h_ones, bus.m_tens, bus.m_ones, bus.s_tens, bus.s_ones});
    end
    nvec++;
    if ({bus.on_h, bus.on_m, bus.flash, bus.sec_pulse} !== 4'b0) begin
      nerr++; $display("FAIL async_rst_flags got %b want 0000",
        {bus.on_h, bus.on_m, bus.flash, bus.sec_pulse});
    end
    @(posedge clk); #1;
    rst = 1'b0; pre_m = 0; st_m = 0;
    step();
    nvec++;
    if ({bus.on_h, bus.on_m, bus.m_tens, bus.m_ones} !== 10'b0) begin
      nerr++; $display("FAIL post_rst_run got on=%b%b m=%h", bus.on_h, bus.on_m,
        {bus.m_tens, bus.m_ones});
    end
  endtask

  initial begin
    test_reset();
    test_set_hours();
    test_set_minutes();
    test_simultaneous();
    test_rollover();
    test_reset_mid_edit();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
